// File: rtl/sp_ram_arbiter.sv
// Two-requester arbiter in front of an internal read-first single-port RAM.
// Define SP_RAM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module sp_ram_arbiter #(
  parameter  int DW    = 8,
  parameter  int WORDS = 256,
  localparam int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata
);

  logic          gnt0_c, gnt1_c;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [AW-1:0] addr_d, addr_q;
  logic          rvalid0_d, rvalid0_q;
  logic          rvalid1_d, rvalid1_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] mem_q [WORDS];

`ifdef SP_RAM_ARB_RR_EN
  // Index of the most recent winner; reset to 1 so requester 0 takes the first contention.
  logic last_d, last_q;
`endif

  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!rst) begin
`ifdef SP_RAM_ARB_RR_EN
      if (req0 && req1) begin
        gnt0_c = last_q;
        gnt1_c = !last_q;
      end else begin
        gnt0_c = req0;
        gnt1_c = req1;
      end
`else
      gnt0_c = req0;
      gnt1_c = req1 && !req0;
`endif
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_din   = din0;
    addr_d    = addr_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
`ifdef SP_RAM_ARB_RR_EN
    last_d    = last_q;
`endif
    if (gnt0_c) begin
      ram_we    = we0;
      ram_din   = din0;
      addr_d    = addr0;
      rvalid0_d = !we0;
`ifdef SP_RAM_ARB_RR_EN
      last_d    = 1'b0;
`endif
    end else if (gnt1_c) begin
      ram_we    = we1;
      ram_din   = din1;
      addr_d    = addr1;
      rvalid1_d = !we1;
`ifdef SP_RAM_ARB_RR_EN
      last_d    = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
`ifdef SP_RAM_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      addr_q    <= addr_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
`ifdef SP_RAM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  // RAM array is not reset; the output register samples the old word on a write (read-first).
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[addr_d] <= ram_din;
    end
    rdata_q <= mem_q[addr_d];
  end

  assign gnt0    = gnt0_c;
  assign gnt1    = gnt1_c;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter: a behavioural model predicts grants and read data,
// a negedge monitor compares them against the DUT. Honours SP_RAM_ARB_RR_EN like the RTL.
module tb_sp_ram_arbiter;

  typedef struct {
    bit       idle;
    bit       we;
    bit [7:0] addr;
    bit [7:0] data;
  } op_t;

  typedef struct {
    int       due;
    bit [7:0] data;
  } exp_t;

  logic       clk, rst;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, din0, din1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   took0   = 0;
  bit   took1   = 0;
  int   last_m  = 1;
  bit [7:0] mem_m [256];
  op_t  ops0[$], ops1[$];
  exp_t exp0[$], exp1[$];

  sp_ram_arbiter #(.DW(8), .WORDS(256)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor first (what the DUT presents now), then the model decides this cycle's grant.
  always @(negedge clk) begin
    bit due0, due1;
    int w;
    due0 = (exp0.size() > 0) && (exp0[0].due == cyc);
    due1 = (exp1.size() > 0) && (exp1[0].due == cyc);
    if (!rst) begin
      chk("rvalid0", {31'd0, rvalid0}, {31'd0, due0});
      chk("rvalid1", {31'd0, rvalid1}, {31'd0, due1});
      if (due0 && rvalid0) chk("rdata0", {24'd0, rdata}, {24'd0, exp0[0].data});
      if (due1 && rvalid1) chk("rdata1", {24'd0, rdata}, {24'd0, exp1[0].data});
    end
    if (due0) void'(exp0.pop_front());
    if (due1) void'(exp1.pop_front());

    w = -1;
    if (rst) begin
      last_m = 1;
    end else if (req0 && req1) begin
`ifdef SP_RAM_ARB_RR_EN
      w = (last_m == 0) ? 1 : 0;
`else
      w = 0;
`endif
    end else if (req0) begin
      w = 0;
    end else if (req1) begin
      w = 1;
    end
    chk("gnt0", {31'd0, gnt0}, {31'd0, (w == 0)});
    chk("gnt1", {31'd0, gnt1}, {31'd0, (w == 1)});
    took0 = (w == 0);
    took1 = (w == 1);
    if (w == 0) begin
      if (we0) mem_m[addr0] = din0;
      else exp0.push_back('{due: cyc + 1, data: mem_m[addr0]});
      last_m = 0;
    end else if (w == 1) begin
      if (we1) mem_m[addr1] = din1;
      else exp1.push_back('{due: cyc + 1, data: mem_m[addr1]});
      last_m = 1;
    end
  end

  task automatic add_op(input int n, input bit idle, input bit we, input bit [7:0] a, input bit [7:0] d);
    op_t op;
    op = '{idle: idle, we: we, addr: a, data: d};
    if (n == 0) ops0.push_back(op);
    else ops1.push_back(op);
  endtask

  // Requester behaviour: hold an op until the edge that grants it, then present the next.
  task automatic run_ops();
    bit  hold0 = 0, hold1 = 0;
    int  guard = 0;
    op_t op;
    while ((ops0.size() > 0 || ops1.size() > 0 || hold0 || hold1) && guard < 4000) begin
      @(posedge clk);
      #1;
      guard++;
      if (hold0 && took0) hold0 = 0;
      if (hold1 && took1) hold1 = 0;
      if (!hold0) begin
        req0 = 1'b0;
        if (ops0.size() > 0) begin
          op = ops0.pop_front();
          if (!op.idle) begin
            req0 = 1'b1; we0 = op.we; addr0 = op.addr; din0 = op.data; hold0 = 1;
          end
        end
      end
      if (!hold1) begin
        req1 = 1'b0;
        if (ops1.size() > 0) begin
          op = ops1.pop_front();
          if (!op.idle) begin
            req1 = 1'b1; we1 = op.we; addr1 = op.addr; din1 = op.data; hold1 = 1;
          end
        end
      end
    end
    if (guard >= 4000) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_ops: cycle budget expired with requests pending (cycle %0d)", cyc);
      ops0.delete();
      ops1.delete();
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; din0 = 0; din1 = 0;
    idle(3);
    rst = 1'b0;
    idle(4);

    // Single write then read on requester 0.
    add_op(0, 0, 1, 8'h05, 8'h5A);
    add_op(0, 0, 0, 8'h05, 8'h00);
    run_ops(); idle(2);

    // Seed two words, then both requesters read for 4 accesses each.
    add_op(0, 0, 1, 8'h01, 8'h11);
    run_ops();
    add_op(1, 0, 1, 8'h02, 8'h22);
    run_ops(); idle(1);
    for (int i = 0; i < 4; i++) begin
      add_op(0, 0, 0, 8'h01, 8'h00);
      add_op(1, 0, 0, 8'h02, 8'h00);
    end
    run_ops(); idle(2);

    // Write on requester 0 racing a read of the same word on requester 1.
    add_op(0, 0, 1, 8'h10, 8'hA5);
    add_op(1, 0, 0, 8'h10, 8'h00);
    run_ops(); idle(2);

    // Reset while a read is in flight; both requests held through reset.
    req1 = 1; we1 = 0; addr1 = 8'h10;
    @(posedge clk); #1;
    rst = 1; req0 = 1; we0 = 0; addr0 = 8'h05;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    req0 = 0;
    @(posedge clk); #1;
    req1 = 0;
    idle(2);

    // Sweep: requester 0 writes every word, requester 1 reads all back-to-back.
    for (int a = 0; a < 256; a++) add_op(0, 0, 1, 8'(a), 8'(a) ^ 8'hFF);
    run_ops(); idle(1);
    for (int a = 0; a < 256; a++) add_op(1, 0, 0, 8'(a), 8'h00);
    add_op(1, 0, 0, 8'h00, 8'h00);
    run_ops(); idle(2);

    // Random mixed traffic on both requesters.
    for (int i = 0; i < 150; i++) begin
      add_op(0, ($urandom_range(2) == 0), $urandom_range(1), 8'($urandom), 8'($urandom));
      add_op(1, ($urandom_range(2) == 0), $urandom_range(1), 8'($urandom), 8'($urandom));
    end
    run_ops(); idle(3);

    chk("exp0_drained", exp0.size(), 0);
    chk("exp1_drained", exp1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
